alu_result_buffer: RTL and testbench

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_result_buffer.sv | 95 +++++++++
 tb/tb_alu_result_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// ALU result buffer: small FIFO between the ALU and writeback, one cycle push-to-head latency.
// Optional stall counter enabled by defining ALU_RESULT_BUFFER_PERF_EN.
package riscv;
  localparam int unsigned XLEN = 64;
endpackage

module alu_result_buffer #(
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       alu_valid_i,
  output logic                       alu_ready_o,
  input  logic [riscv::XLEN-1:0]     result_i,
  input  logic                       branch_res_i,
  input  logic [TRANS_ID_BITS-1:0]   trans_id_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [riscv::XLEN-1:0]     wb_result_o,
  output logic                       wb_branch_res_o,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [31:0]                stall_cnt_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [riscv::XLEN-1:0]   result;
    logic                     branch_res;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             entry_in, head;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               push, pop;

  assign alu_ready_o = (count_q < CNT_W'(DEPTH));
  assign wb_valid_o  = (count_q != '0);
  assign push        = alu_valid_i & alu_ready_o;
  assign pop         = wb_valid_o & wb_ready_i;
  assign count_o     = count_q;

  assign entry_in = '{result: result_i, branch_res: branch_res_i, trans_id: trans_id_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is unreset; empty-state outputs are masked below.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wr_ptr_q] <= entry_in;
  end

  assign head            = mem[rd_ptr_q];
  assign wb_result_o     = wb_valid_o ? head.result     : '0;
  assign wb_branch_res_o = wb_valid_o ? head.branch_res : 1'b0;
  assign wb_trans_id_o   = wb_valid_o ? head.trans_id   : '0;

`ifdef ALU_RESULT_BUFFER_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      stall_cnt_q <= '0;
    else if (wb_valid_o && !wb_ready_i && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer (DEPTH=2, TRANS_ID_BITS=3).
module tb_alu_result_buffer;
  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   flush_i;
  logic                   alu_valid_i;
  logic                   alu_ready_o;
  logic [riscv::XLEN-1:0] result_i;
  logic                   branch_res_i;
  logic [2:0]             trans_id_i;
  logic                   wb_valid_o;
  logic                   wb_ready_i;
  logic [riscv::XLEN-1:0] wb_result_o;
  logic                   wb_branch_res_o;
  logic [2:0]             wb_trans_id_o;
  logic [1:0]             count_o;
  logic [31:0]            stall_cnt_o;

  int nvec = 0;
  int nerr = 0;

  alu_result_buffer #(.DEPTH(2), .TRANS_ID_BITS(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .result_i(result_i), .branch_res_i(branch_res_i), .trans_id_i(trans_id_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_result_o(wb_result_o), .wb_branch_res_o(wb_branch_res_o),
    .wb_trans_id_o(wb_trans_id_o), .count_o(count_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; flush_i = 1'b0; alu_valid_i = 1'b0; wb_ready_i = 1'b0;
    result_i = '0; branch_res_i = 1'b0; trans_id_i = '0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (count_o !== 2'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", count_o); end
    nvec++; if (wb_valid_o !== 1'b0) begin nerr++; $display("FAIL reset_wb_valid got %b want 0", wb_valid_o); end
    nvec++; if (alu_ready_o !== 1'b1) begin nerr++; $display("FAIL reset_alu_ready got %b want 1", alu_ready_o); end
    nvec++; if (wb_result_o !== 64'h0 || wb_trans_id_o !== 3'd0 || wb_branch_res_o !== 1'b0) begin
      nerr++; $display("FAIL reset_wb_zero got %h/%0d/%b want 0/0/0", wb_result_o, wb_trans_id_o, wb_branch_res_o); end
    nvec++; if (stall_cnt_o !== 32'd0) begin nerr++; $display("FAIL reset_stall got %0d want 0", stall_cnt_o); end
  endtask

  task automatic test_single();
    alu_valid_i = 1'b1; result_i = 64'h7F; trans_id_i = 3'd2; branch_res_i = 1'b0;
    tick();
    alu_valid_i = 1'b0;
    nvec++; if (wb_valid_o !== 1'b1) begin nerr++; $display("FAIL single_valid got %b want 1", wb_valid_o); end
    nvec++; if (wb_result_o !== 64'h7F) begin nerr++; $display("FAIL single_result got %h want 7f", wb_result_o); end
    nvec++; if (wb_trans_id_o !== 3'd2) begin nerr++; $display("FAIL single_tag got %0d want 2", wb_trans_id_o); end
    nvec++; if (count_o !== 2'd1) begin nerr++; $display("FAIL single_count got %0d want 1", count_o); end
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    nvec++; if (count_o !== 2'd0 || wb_valid_o !== 1'b0 || wb_result_o !== 64'h0) begin
      nerr++; $display("FAIL single_pop got cnt=%0d v=%b r=%h want 0/0/0", count_o, wb_valid_o, wb_result_o); end
  endtask

  task automatic test_full();
    wb_ready_i = 1'b0;
    alu_valid_i = 1'b1; result_i = 64'h01; trans_id_i = 3'd1; branch_res_i = 1'b0;
    tick();
    result_i = 64'h81; trans_id_i = 3'd3; branch_res_i = 1'b1;
    tick();
    nvec++; if (alu_ready_o !== 1'b0) begin nerr++; $display("FAIL full_ready got %b want 0", alu_ready_o); end
    nvec++; if (count_o !== 2'd2) begin nerr++; $display("FAIL full_count got %0d want 2", count_o); end
    result_i = 64'h55; trans_id_i = 3'd5; branch_res_i = 1'b0;
    tick();
    nvec++; if (count_o !== 2'd2 || wb_result_o !== 64'h01) begin
      nerr++; $display("FAIL full_ignore got cnt=%0d head=%h want 2/01", count_o, wb_result_o); end
    // Full with a same-cycle pop must still refuse the push.
    wb_ready_i = 1'b1;
    nvec++; if (alu_ready_o !== 1'b0) begin nerr++; $display("FAIL full_ready_pop got %b want 0", alu_ready_o); end
    tick();
    alu_valid_i = 1'b0;
    nvec++; if (count_o !== 2'd1 || wb_result_o !== 64'h81 || wb_trans_id_o !== 3'd3 || wb_branch_res_o !== 1'b1) begin
      nerr++; $display("FAIL full_pop2 got cnt=%0d r=%h t=%0d b=%b want 1/81/3/1", count_o, wb_result_o, wb_trans_id_o, wb_branch_res_o); end
    tick();
    wb_ready_i = 1'b0;
    nvec++; if (count_o !== 2'd0 || wb_valid_o !== 1'b0) begin
      nerr++; $display("FAIL full_drain got cnt=%0d v=%b want 0/0", count_o, wb_valid_o); end
  endtask

  task automatic test_back_to_back();
    alu_valid_i = 1'b1; result_i = 64'h20; trans_id_i = 3'd4; branch_res_i = 1'b0; wb_ready_i = 1'b0;
    tick();
    result_i = 64'h10; trans_id_i = 3'd6; wb_ready_i = 1'b1;
    tick();
    nvec++; if (count_o !== 2'd1 || wb_result_o !== 64'h10 || wb_trans_id_o !== 3'd6) begin
      nerr++; $display("FAIL b2b_first got cnt=%0d r=%h t=%0d want 1/10/6", count_o, wb_result_o, wb_trans_id_o); end
    for (int i = 0; i < 10; i++) begin
      result_i = 64'h100 + 64'(i); trans_id_i = 3'(i); branch_res_i = i[0];
      tick();
      nvec++; if (count_o !== 2'd1 || wb_result_o !== 64'h100 + 64'(i) || wb_trans_id_o !== 3'(i) || wb_branch_res_o !== i[0]) begin
        nerr++; $display("FAIL b2b_wrap%0d got cnt=%0d r=%h t=%0d b=%b want 1/%h/%0d/%b", i, count_o, wb_result_o,
                         wb_trans_id_o, wb_branch_res_o, 64'h100 + 64'(i), i % 8, i[0]); end
    end
    alu_valid_i = 1'b0;
    tick();
    wb_ready_i = 1'b0;
    nvec++; if (count_o !== 2'd0) begin nerr++; $display("FAIL b2b_drain got %0d want 0", count_o); end
  endtask

  task automatic test_flush();
    alu_valid_i = 1'b1; result_i = 64'hA1; trans_id_i = 3'd1; wb_ready_i = 1'b0;
    tick();
    result_i = 64'hA2; trans_id_i = 3'd2;
    tick();
    flush_i = 1'b1; result_i = 64'hA3; trans_id_i = 3'd3; branch_res_i = 1'b1;
    tick();
    flush_i = 1'b0; alu_valid_i = 1'b0;
    nvec++; if (count_o !== 2'd0 || wb_valid_o !== 1'b0 || alu_ready_o !== 1'b1) begin
      nerr++; $display("FAIL flush_state got cnt=%0d v=%b rdy=%b want 0/0/1", count_o, wb_valid_o, alu_ready_o); end
    nvec++; if (wb_result_o !== 64'h0 || wb_trans_id_o !== 3'd0 || wb_branch_res_o !== 1'b0) begin
      nerr++; $display("FAIL flush_zero got %h/%0d/%b want 0/0/0", wb_result_o, wb_trans_id_o, wb_branch_res_o); end
    alu_valid_i = 1'b1; result_i = 64'hB0; trans_id_i = 3'd7; branch_res_i = 1'b0;
    tick();
    alu_valid_i = 1'b0;
    nvec++; if (count_o !== 2'd1 || wb_result_o !== 64'hB0 || wb_trans_id_o !== 3'd7) begin
      nerr++; $display("FAIL flush_after got cnt=%0d r=%h t=%0d want 1/b0/7", count_o, wb_result_o, wb_trans_id_o); end
  endtask

  task automatic test_perf();
    logic [31:0] exp5;
`ifdef ALU_RESULT_BUFFER_PERF_EN
    exp5 = 32'd5;
`else
    exp5 = 32'd0;
`endif
    do_reset();
    alu_valid_i = 1'b1; result_i = 64'hC0; trans_id_i = 3'd0;
    tick();
    alu_valid_i = 1'b0;
    nvec++; if (stall_cnt_o !== 32'd0) begin nerr++; $display("FAIL perf_start got %0d want 0", stall_cnt_o); end
    repeat (5) tick();
    nvec++; if (stall_cnt_o !== exp5) begin nerr++; $display("FAIL perf_held got %0d want %0d", stall_cnt_o, exp5); end
    flush_i = 1'b1; wb_ready_i = 1'b1;
    tick();
    flush_i = 1'b0; wb_ready_i = 1'b0;
    repeat (2) tick();
    nvec++; if (stall_cnt_o !== exp5) begin nerr++; $display("FAIL perf_flush got %0d want %0d", stall_cnt_o, exp5); end
  endtask

  task automatic test_async_reset();
    alu_valid_i = 1'b1; result_i = 64'hD1; trans_id_i = 3'd1;
    tick();
    result_i = 64'hD2; trans_id_i = 3'd2;
    tick();
    alu_valid_i = 1'b0;
    nvec++; if (count_o !== 2'd2) begin nerr++; $display("FAIL areset_pre got %0d want 2", count_o); end
    #2 rst_ni = 1'b0;
    #1;
    nvec++; if (count_o !== 2'd0 || alu_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
      nerr++; $display("FAIL areset_now got cnt=%0d rdy=%b v=%b want 0/1/0", count_o, alu_ready_o, wb_valid_o); end
    rst_ni = 1'b1;
    alu_valid_i = 1'b1; result_i = 64'h33; trans_id_i = 3'd5;
    tick();
    alu_valid_i = 1'b0;
    nvec++; if (count_o !== 2'd1 || wb_result_o !== 64'h33 || wb_trans_id_o !== 3'd5) begin
      nerr++; $display("FAIL areset_head got cnt=%0d r=%h t=%0d want 1/33/5", count_o, wb_result_o, wb_trans_id_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_flush();
    test_perf();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
